// File: rtl/ising_ctrl_pkg.sv
// Shared types and defaults for the Ising array anneal sequencer.
//   seq_state_e    : sequencer state encoding
//   anneal_cfg_t   : configuration captured when a start is accepted
//   last_run_idx() : index of the final iteration; a run count of 0 means one run
// Latched config fields are CFG_TW / CFG_RW wide so the struct serves any
// TW <= 32 and RW <= 16. Inputs are zero-extended into it.
package ising_ctrl_pkg;

  localparam int DEF_TW         = 16;
  localparam int DEF_RW         = 8;
  localparam int DEF_SAMPLE_LEN = 6;

  localparam int CFG_TW = 32;
  localparam int CFG_RW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ANNEAL = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [CFG_TW-1:0] shil_l;
    logic [CFG_TW-1:0] wt_l;
    logic [CFG_TW-1:0] sample_l;
    logic [CFG_RW-1:0] runs_l;
  } anneal_cfg_t;

  function automatic logic [CFG_RW-1:0] last_run_idx(input logic [CFG_RW-1:0] runs);
    return (runs == '0) ? '0 : runs - CFG_RW'(1);
  endfunction

endpackage

// File: rtl/ising_phase_timer.sv
// Saturating up-counter used for the anneal phase timer and the sample counter.
//   clk    : rising-edge clock
//   resetb : asynchronous active-low reset, count -> 0
//   clr    : synchronous clear (wins over en)
//   en     : count enable; the count holds at all-ones
//   cnt    : current count
module ising_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ising_anneal_sequencer.sv
// Multi-run anneal sequencer for the Ising oscillator array.
// Each iteration is an ANNEAL phase with SHIL and weight enables decoded from
// the phase timer t, then a SAMPLE window of SAMPLE_LEN cycles. Iterations
// run back-to-back until the latched run count is reached. Then done pulses.
//   clk, resetb        : array clock, async active-low reset
//   prog_done          : array programmed; low aborts a run and blocks start
//   start              : level start request, honoured in IDLE only
//   shil_time, weight_time_off, sample_time, num_runs : latched on start
//   fails_reached      : abort request
//   shil_enb, weight_enb, sample, run_idx, busy, done, aborted : registered outputs
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start with prog_done high
// S_ANNEAL | t counting; enables decoded from t and the latched config
// S_SAMPLE | sample window; s counts 0..SAMPLE_LEN-1 and t keeps counting
// S_DONE   | single-cycle completion pulse
//
// Every output port is a flop loaded from a decode of the current state,
// timer and config. Output ports therefore trail the internal state by one
// edge. busy appears the edge after start is sampled. Outputs clear the edge
// after an abort is taken.
module ising_anneal_sequencer
  import ising_ctrl_pkg::*;
#(
  parameter int TW         = DEF_TW,
  parameter int RW         = DEF_RW,
  parameter int SAMPLE_LEN = DEF_SAMPLE_LEN
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          prog_done,
  input  logic          start,
  input  logic [TW-1:0] shil_time,
  input  logic [TW-1:0] weight_time_off,
  input  logic [TW-1:0] sample_time,
  input  logic [RW-1:0] num_runs,
  input  logic          fails_reached,
  output logic          shil_enb,
  output logic          weight_enb,
  output logic          sample,
  output logic [RW-1:0] run_idx,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam int SW = $clog2(SAMPLE_LEN + 1);

  seq_state_e    state_q, state_d;
  anneal_cfg_t   cfg_q, cfg_d;
  logic [RW-1:0] idx_q, idx_d;
  logic          abort_flag_q, abort_flag_d;

  logic          shil_enb_q, shil_enb_d;
  logic          weight_enb_q, weight_enb_d;
  logic          sample_q, sample_d;
  logic [RW-1:0] run_idx_q, run_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic [TW-1:0] t_cnt;
  logic [SW-1:0] s_cnt;
  logic          t_clr, t_en, s_clr, s_en;
  logic          abort_req;
  logic          in_run;

  ising_phase_timer #(.W(TW)) u_t_timer (
    .clk    (clk),
    .resetb (resetb),
    .clr    (t_clr),
    .en     (t_en),
    .cnt    (t_cnt)
  );

  ising_phase_timer #(.W(SW)) u_s_timer (
    .clk    (clk),
    .resetb (resetb),
    .clr    (s_clr),
    .en     (s_en),
    .cnt    (s_cnt)
  );

  assign abort_req = fails_reached | ~prog_done;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    idx_d        = idx_q;
    abort_flag_d = abort_flag_q;
    t_clr        = 1'b0;
    t_en         = 1'b0;
    s_clr        = 1'b1;
    s_en         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && prog_done) begin
          state_d        = S_ANNEAL;
          cfg_d.shil_l   = CFG_TW'(shil_time);
          cfg_d.wt_l     = CFG_TW'(weight_time_off);
          cfg_d.sample_l = CFG_TW'(sample_time);
          cfg_d.runs_l   = CFG_RW'(num_runs);
          idx_d          = '0;
          abort_flag_d   = 1'b0;
          t_clr          = 1'b1;
        end
      end
      S_ANNEAL: begin
        if (abort_req) begin
          state_d      = S_IDLE;
          abort_flag_d = 1'b1;
        end else begin
          t_en = 1'b1;
          if (CFG_TW'(t_cnt) == cfg_q.sample_l) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort_req) begin
          state_d      = S_IDLE;
          abort_flag_d = 1'b1;
        end else begin
          t_en  = 1'b1;
          s_clr = 1'b0;
          s_en  = 1'b1;
          if (s_cnt == SW'(SAMPLE_LEN - 1)) begin
            s_clr = 1'b1;
            if (CFG_RW'(idx_q) == last_run_idx(cfg_q.runs_l)) begin
              state_d = S_DONE;
            end else begin
              // Next iteration starts with no gap: t restarts from zero.
              state_d = S_ANNEAL;
              t_clr   = 1'b1;
              idx_d   = idx_q + RW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_run       = (state_q == S_ANNEAL) || (state_q == S_SAMPLE);
    busy_d       = in_run;
    shil_enb_d   = in_run && ((cfg_q.shil_l == '0) || (CFG_TW'(t_cnt) < cfg_q.shil_l));
    weight_enb_d = in_run && ((cfg_q.wt_l == '0) || (CFG_TW'(t_cnt) < cfg_q.wt_l));
    sample_d     = (state_q == S_SAMPLE);
    done_d       = (state_q == S_DONE);
    run_idx_d    = idx_q;
    aborted_d    = abort_flag_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      idx_q        <= '0;
      abort_flag_q <= 1'b0;
      shil_enb_q   <= 1'b0;
      weight_enb_q <= 1'b0;
      sample_q     <= 1'b0;
      run_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      idx_q        <= idx_d;
      abort_flag_q <= abort_flag_d;
      shil_enb_q   <= shil_enb_d;
      weight_enb_q <= weight_enb_d;
      sample_q     <= sample_d;
      run_idx_q    <= run_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign shil_enb   = shil_enb_q;
  assign weight_enb = weight_enb_q;
  assign sample     = sample_q;
  assign run_idx    = run_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_ising_anneal_sequencer.sv
// Bench for ising_anneal_sequencer: a position-based model (iteration number
// and offset derived from a cycle count by division) is checked every cycle.
// Hand-computed scenario totals pin the model.
module tb_ising_anneal_sequencer;

  localparam int TW = 16;
  localparam int RW = 8;
  localparam int SL = 6;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          prog_done = 1'b0;
  logic          start = 1'b0;
  logic          fails_reached = 1'b0;
  logic [TW-1:0] shil_time = '0;
  logic [TW-1:0] weight_time_off = '0;
  logic [TW-1:0] sample_time = '0;
  logic [RW-1:0] num_runs = '0;
  logic          shil_enb, weight_enb, sample, busy, done, aborted;
  logic [RW-1:0] run_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ising_anneal_sequencer #(.TW(TW), .RW(RW), .SAMPLE_LEN(SL)) dut (
    .clk             (clk),
    .resetb          (resetb),
    .prog_done       (prog_done),
    .start           (start),
    .shil_time       (shil_time),
    .weight_time_off (weight_time_off),
    .sample_time     (sample_time),
    .num_runs        (num_runs),
    .fails_reached   (fails_reached),
    .shil_enb        (shil_enb),
    .weight_enb      (weight_enb),
    .sample          (sample),
    .run_idx         (run_idx),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted)
  );

  // Model: phase 0 idle, 1 running (position m_c cycles since the run began), 2 done.
  int m_phase = 0, m_c = 0, m_s = 0, m_w = 0, m_l = 0, m_n = 1, m_idx = 0, m_ab = 0;
  int iter = 0, p = 0, tt = 0;
  logic e_shil = 0, e_wt = 0, e_smp = 0, e_busy = 0, e_done = 0, e_ab = 0;
  logic [RW-1:0] e_idx = '0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_phase = 0; m_c = 0; m_idx = 0; m_ab = 0;
      e_shil = 0; e_wt = 0; e_smp = 0; e_busy = 0; e_done = 0; e_ab = 0; e_idx = '0;
    end else begin
      iter   = m_l + 1 + SL;
      e_shil = 0; e_wt = 0; e_smp = 0; e_busy = 0; e_done = 0;
      e_ab   = (m_ab != 0);
      e_idx  = RW'(m_idx);
      if (m_phase == 1) begin
        p      = m_c % iter;
        tt     = (p > 65535) ? 65535 : p;
        e_busy = 1;
        e_smp  = (p > m_l);
        e_shil = (m_s == 0) || (tt < m_s);
        e_wt   = (m_w == 0) || (tt < m_w);
        e_idx  = RW'(m_c / iter);
      end else if (m_phase == 2) begin
        e_done = 1;
        e_idx  = RW'(m_n - 1);
      end
      case (m_phase)
        1: begin
          if (fails_reached || !prog_done) begin
            m_idx = m_c / iter; m_ab = 1; m_phase = 0;
          end else begin
            m_c++;
            if (m_c == m_n * iter) begin m_phase = 2; m_idx = m_n - 1; end
          end
        end
        2: m_phase = 0;
        default: begin
          if (start && prog_done) begin
            m_phase = 1; m_c = 0; m_ab = 0; m_idx = 0;
            m_s = int'(shil_time); m_w = int'(weight_time_off); m_l = int'(sample_time);
            m_n = (num_runs == 0) ? 1 : int'(num_runs);
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({shil_enb, weight_enb, sample, busy, done, aborted, run_idx} !==
        {e_shil, e_wt, e_smp, e_busy, e_done, e_ab, e_idx}) begin
      failures++;
      $display("FAIL cycle_compare @%0t got shil=%b wt=%b smp=%b busy=%b done=%b ab=%b idx=%0d want shil=%b wt=%b smp=%b busy=%b done=%b ab=%b idx=%0d",
               $time, shil_enb, weight_enb, sample, busy, done, aborted, run_idx,
               e_shil, e_wt, e_smp, e_busy, e_done, e_ab, e_idx);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int s, input int w, input int l, input int n);
    shil_time = TW'(s); weight_time_off = TW'(w); sample_time = TW'(l); num_runs = RW'(n);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Index j = number of edges since the start edge (j=0 is that edge itself).
  int sh_c, wt_c, sm_c, bs_c, dn_c, first_busy, first_smp, done_at;
  logic [RW-1:0] idx_at [0:99];

  task automatic run_measure(input int ncyc);
    sh_c = 0; wt_c = 0; sm_c = 0; bs_c = 0; dn_c = 0;
    first_busy = -1; first_smp = -1; done_at = -1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      idx_at[j] = run_idx;
      if (shil_enb)   sh_c++;
      if (weight_enb) wt_c++;
      if (sample)     sm_c++;
      if (busy)       bs_c++;
      if (done)       dn_c++;
      if (busy && first_busy < 0)  first_busy = j;
      if (sample && first_smp < 0) first_smp = j;
      if (done && done_at < 0)     done_at = j;
    end
  endtask

  int found;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({shil_enb, weight_enb, sample, busy, done, aborted, run_idx}), 0);
    resetb = 1'b1;
    prog_done = 1'b1;
    @(posedge clk); #1;

    // Single iteration: 4 SHIL cycles, 8 weight cycles, 6 sample cycles.
    set_cfg(4, 8, 12, 1);
    do_start();
    run_measure(30);
    chk("t1_first_busy", first_busy, 1);
    chk("t1_sample_after_busy", first_smp - first_busy, 13);
    chk("t1_sample_len", sm_c, 6);
    chk("t1_shil_cycles", sh_c, 4);
    chk("t1_weight_cycles", wt_c, 8);
    chk("t1_busy_cycles", bs_c, 19);
    chk("t1_done_at", done_at, 20);
    chk("t1_done_count", dn_c, 1);

    // Three iterations, enables always on; config changed mid-run must not matter.
    set_cfg(0, 0, 5, 3);
    do_start();
    set_cfg(3, 2, 1, 1);
    run_measure(45);
    chk("t2_shil_cycles", sh_c, 36);
    chk("t2_weight_cycles", wt_c, 36);
    chk("t2_sample_cycles", sm_c, 18);
    chk("t2_done_at", done_at, 37);
    chk("t2_idx_run0", int'(idx_at[12]), 0);
    chk("t2_idx_run1", int'(idx_at[13]), 1);
    chk("t2_idx_run2", int'(idx_at[25]), 2);
    chk("t2_idx_hold", int'(idx_at[40]), 2);

    // Abort during SAMPLE of run 1.
    set_cfg(2, 2, 3, 4);
    do_start();
    found = 0;
    for (int j = 0; j < 100 && found == 0; j++) begin
      @(negedge clk);
      if (sample && run_idx == 1) found = 1;
    end
    chk("t3_reach_run1_sample", found, 1);
    fails_reached = 1'b1;
    @(posedge clk); #1;
    fails_reached = 1'b0;
    run_measure(6);
    chk("t3_no_done", dn_c, 0);
    chk("t3_aborted", int'(aborted), 1);
    chk("t3_idle", int'(busy), 0);
    chk("t3_idx_kept", int'(run_idx), 1);
    do_start();
    run_measure(3);
    chk("t3_restart_busy", first_busy, 1);
    chk("t3_aborted_cleared", int'(aborted), 0);

    // prog_done lost mid-ANNEAL, then start ignored while prog_done is low.
    set_cfg(5, 5, 10, 2);
    repeat (40) @(posedge clk);
    #1;
    do_start();
    repeat (3) @(posedge clk);
    #1;
    prog_done = 1'b0;
    run_measure(5);
    chk("t4_aborted", int'(aborted), 1);
    chk("t4_idle", int'(busy), 0);
    chk("t4_no_done", dn_c, 0);
    start = 1'b1;
    run_measure(10);
    chk("t4_start_ignored", bs_c, 0);
    start = 1'b0;
    prog_done = 1'b1;

    // Asynchronous reset in the middle of a sample window.
    set_cfg(1, 1, 4, 3);
    do_start();
    found = 0;
    for (int j = 0; j < 60 && found == 0; j++) begin
      @(negedge clk);
      if (sample) found = 1;
    end
    chk("t5_reach_sample", found, 1);
    #2 resetb = 1'b0;
    #1;
    chk("t5_async_reset_outputs", int'({shil_enb, weight_enb, sample, busy, done, aborted, run_idx}), 0);
    @(posedge clk); #1;
    resetb = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start         = ($urandom_range(0, 2) == 0);
      fails_reached = ($urandom_range(0, 299) == 0);
      prog_done     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        set_cfg($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 20), $urandom_range(0, 3));
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
